spectrum_scan_ctrl: RTL

// - Sequences one spectrum acquisition: re-arms the FFT-magnitude capture stage, waits for its
//   RAM-write-done flag, then scans the magnitude RAM and reports the two largest bins.
// - Sits between the key/trigger logic and the FFT-modulus/RAM stage. It replaces the manual key restart.

---
 rtl/spectrum_pkg.sv | 28 ++
 rtl/spectrum_peak_tracker.sv | 76 +++++++
 rtl/spectrum_scan_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spectrum_pkg.sv
// Shared definitions for the spectrum scan controller.
// Contents:
//   - default sizes for the magnitude RAM (bin count, address and magnitude widths)
//   - FSM state encoding used by spectrum_scan_ctrl
//   - max3 helper used to size the shared phase counter
package spectrum_pkg;

  localparam int unsigned N_BINS_DEF = 128;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned MAG_W_DEF  = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ARM    = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_SCAN   = 3'd3;
  localparam state_t ST_DRAIN  = 3'd4;
  localparam state_t ST_REPORT = 3'd5;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spectrum_peak_tracker.sv
// Running top-2 search over a stream of (bin, magnitude) pairs.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           zero both peaks (start of an acquisition)
//   valid_in        bin_in/mag_in carry a bin that takes part in the search
//   bin_in, mag_in  returned bin index and its unsigned magnitude
//   p1_*_nxt        largest peak including the current input
//   p2_*_nxt        second-largest peak including the current input
// The *_nxt outputs are the post-update values, so the owner can latch the final
// result on the same edge that absorbs the last bin.
module spectrum_peak_tracker
  import spectrum_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned MAG_W  = MAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] bin_in,
  input  logic [MAG_W-1:0]  mag_in,
  output logic [ADDR_W-1:0] p1_bin_nxt,
  output logic [MAG_W-1:0]  p1_mag_nxt,
  output logic [ADDR_W-1:0] p2_bin_nxt,
  output logic [MAG_W-1:0]  p2_mag_nxt
);

  logic [ADDR_W-1:0] p1_bin_q, p1_bin_d, p2_bin_q, p2_bin_d;
  logic [MAG_W-1:0]  p1_mag_q, p1_mag_d, p2_mag_q, p2_mag_d;

  // Strict compares: an equal later bin never displaces an earlier one, so ties
  // resolve to the lower bin because bins arrive in ascending order.
  always_comb begin
    p1_bin_d = p1_bin_q;
    p1_mag_d = p1_mag_q;
    p2_bin_d = p2_bin_q;
    p2_mag_d = p2_mag_q;
    if (clear) begin
      p1_bin_d = '0;
      p1_mag_d = '0;
      p2_bin_d = '0;
      p2_mag_d = '0;
    end else if (valid_in) begin
      if (mag_in > p1_mag_q) begin
        p2_bin_d = p1_bin_q;
        p2_mag_d = p1_mag_q;
        p1_bin_d = bin_in;
        p1_mag_d = mag_in;
      end else if (mag_in > p2_mag_q) begin
        p2_bin_d = bin_in;
        p2_mag_d = mag_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_bin_q <= '0;
      p1_mag_q <= '0;
      p2_bin_q <= '0;
      p2_mag_q <= '0;
    end else begin
      p1_bin_q <= p1_bin_d;
      p1_mag_q <= p1_mag_d;
      p2_bin_q <= p2_bin_d;
      p2_mag_q <= p2_mag_d;
    end
  end

  assign p1_bin_nxt = p1_bin_d;
  assign p1_mag_nxt = p1_mag_d;
  assign p2_bin_nxt = p2_bin_d;
  assign p2_mag_nxt = p2_mag_d;

endmodule

// File: rtl/spectrum_scan_ctrl.sv
// Sequences one spectrum acquisition: re-arms the FFT-magnitude capture stage,
// waits for its RAM-write-done flag, scans the magnitude RAM and reports the two
// largest bins (low DC bins excluded).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle acquisition request (ignored while busy)
//   auto_mode            re-arm automatically whenever idle
//   wr_done              capture stage has written all bins (level)
//   cap_key_n            active-low restart to the capture stage
//   rd_en, rd_addr       magnitude RAM read port
//   rd_data              RAM data, valid RD_LAT cycles after rd_en
//   busy                 high in every state except idle
//   peak1_bin/peak1_mag  largest bin of the last completed scan
//   peak2_bin/peak2_mag  second-largest bin of the last completed scan
//   result_valid         one-cycle pulse when the peak outputs update
//   timeout_err          one-cycle pulse when waiting for wr_done is abandoned
module spectrum_scan_ctrl
  import spectrum_pkg::*;
#(
  parameter int unsigned N_BINS      = N_BINS_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned MAG_W       = MAG_W_DEF,
  parameter int unsigned SKIP_BINS   = 2,
  parameter int unsigned ARM_CYCLES  = 4,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_mode,
  input  logic              wr_done,
  output logic              cap_key_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [MAG_W-1:0]  rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] peak1_bin,
  output logic [MAG_W-1:0]  peak1_mag,
  output logic [ADDR_W-1:0] peak2_bin,
  output logic [MAG_W-1:0]  peak2_mag,
  output logic              result_valid,
  output logic              timeout_err
);

  // One counter serves the ARM length, the WAIT timeout and the DRAIN length.
  localparam int unsigned CNT_MAX = max3(TIMEOUT_CYC, ARM_CYCLES, RD_LAT);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              load_result;

  // Read-data tag pipeline: entry RD_LAT-1 lines up with rd_data.
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] idx_q [RD_LAT];

  logic              trk_valid;
  logic [ADDR_W-1:0] p1_bin_nxt, p2_bin_nxt;
  logic [MAG_W-1:0]  p1_mag_nxt, p2_mag_nxt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    timeout_err = 1'b0;
    load_result = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || auto_mode) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
      end
      ST_ARM: begin
        addr_d = '0;
        if (cnt_q == CNT_W'(ARM_CYCLES - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // wr_done wins over a simultaneous timeout; a level already high is accepted.
        if (wr_done) begin
          state_d = ST_SCAN;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC))) begin
          timeout_err = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SCAN: begin
        if (addr_q == ADDR_W'(N_BINS - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          state_d     = ST_REPORT;
          load_result = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    idx_q[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      idx_q[i] <= idx_q[i-1];
    end
  end

  assign trk_valid = vld_q[RD_LAT-1] && (idx_q[RD_LAT-1] >= ADDR_W'(SKIP_BINS));

  spectrum_peak_tracker #(
    .ADDR_W (ADDR_W),
    .MAG_W  (MAG_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == ST_ARM),
    .valid_in   (trk_valid),
    .bin_in     (idx_q[RD_LAT-1]),
    .mag_in     (rd_data),
    .p1_bin_nxt (p1_bin_nxt),
    .p1_mag_nxt (p1_mag_nxt),
    .p2_bin_nxt (p2_bin_nxt),
    .p2_mag_nxt (p2_mag_nxt)
  );

  // Latched on the edge that absorbs the last bin, so the new values appear in
  // the REPORT cycle and hold until the next report.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak1_bin <= '0;
      peak1_mag <= '0;
      peak2_bin <= '0;
      peak2_mag <= '0;
    end else if (load_result) begin
      peak1_bin <= p1_bin_nxt;
      peak1_mag <= p1_mag_nxt;
      peak2_bin <= p2_bin_nxt;
      peak2_mag <= p2_mag_nxt;
    end
  end

  assign cap_key_n    = (state_q != ST_ARM);
  assign rd_en        = (state_q == ST_SCAN);
  assign rd_addr      = addr_q;
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_REPORT);

endmodule
